// File: rtl/cpu_pkg.sv
// Shared decode-stage definitions: register address width, back-end stage
// indices, the scoreboard entry layout and the forwarding-select encoding.
package cpu_pkg;

    localparam int unsigned RA_W = 5;

    // Back-end stage indices as seen by the scoreboard (0 = youngest).
    localparam int unsigned STG_EXE = 0;
    localparam int unsigned STG_MEM = 1;
    localparam int unsigned STG_WB  = 2;

    // Forwarding select value meaning "take the operand from the register file".
    localparam int unsigned FWD_RF = 0;

    typedef struct packed {
        logic            v;
        logic [RA_W-1:0] wdest;
        logic            is_load;
    } sb_entry_t;

endpackage

// File: rtl/sb_src_match.sv
// Hazard check for one source operand against every in-flight writer.
// The youngest matching writer decides between stall and forward.
module sb_src_match
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH    = 3,
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned ALU_RDY  = 0,
    parameter int unsigned LOAD_RDY = 1,
    parameter int unsigned SEL_W    = 2
) (
    input  logic [RA_W-1:0]        src_i,
    input  logic                   use_i,
    input  sb_entry_t [DEPTH-1:0]  entries_i,
    output logic                   stall_o,
    output logic [SEL_W-1:0]       sel_o
);

    logic             hit;
    logic [SEL_W-1:0] hit_idx;
    logic             hit_load;
    logic [31:0]      rdy;

    // Scan oldest to youngest so the lowest matching index is the one kept.
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        hit_load = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use_i && (src_i != '0) && entries_i[k].v && (entries_i[k].wdest == src_i)) begin
                hit      = 1'b1;
                hit_idx  = SEL_W'(k);
                hit_load = entries_i[k].is_load;
            end
        end
    end

    // Stall while the youngest writer's value is not yet available, else bypass from it.
    always_comb begin
        stall_o = 1'b0;
        sel_o   = SEL_W'(FWD_RF);
        rdy     = hit_load ? LOAD_RDY : ALU_RDY;
        if (hit) begin
            if (!FWD_EN) begin
                stall_o = 1'b1;
            end else if (32'(hit_idx) < rdy) begin
                stall_o = 1'b1;
            end else begin
                sel_o = hit_idx + SEL_W'(1);
            end
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage interlock/bypass unit: a shift-register scoreboard of in-flight
// register writes driving the ID stall, operand forwarding selects and a stall counter.
module id_scoreboard #(
    parameter int unsigned DEPTH    = cpu_pkg::STG_WB + 1,
    parameter int unsigned RA_W     = cpu_pkg::RA_W,
    parameter bit          FWD_EN   = 1'b1,
    parameter int unsigned ALU_RDY  = cpu_pkg::STG_EXE,
    parameter int unsigned LOAD_RDY = cpu_pkg::STG_MEM,
    parameter int unsigned SEL_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             pipe_hold_i,
    input  logic             flush_i,
    input  logic             id_valid_i,
    input  logic [RA_W-1:0]  id_rs_i,
    input  logic             id_rs_use_i,
    input  logic [RA_W-1:0]  id_rt_i,
    input  logic             id_rt_use_i,
    input  logic             id_wen_i,
    input  logic [RA_W-1:0]  id_wdest_i,
    input  logic             id_is_load_i,
    input  logic             id_issue_i,
    output logic             id_stall_o,
    output logic [SEL_W-1:0] rs_fwd_sel_o,
    output logic [SEL_W-1:0] rt_fwd_sel_o,
    output logic [SEL_W-1:0] inflight_cnt_o,
    output logic [31:0]      stall_cnt_o
);
    import cpu_pkg::*;

    sb_entry_t [DEPTH-1:0] entries_q, entries_d;
    logic [SEL_W-1:0]      inflight_q, inflight_d;
    logic [31:0]           stall_cnt_q, stall_cnt_d;
    logic                  rs_stall, rt_stall;

    sb_src_match #(
        .DEPTH    (DEPTH),
        .FWD_EN   (FWD_EN),
        .ALU_RDY  (ALU_RDY),
        .LOAD_RDY (LOAD_RDY),
        .SEL_W    (SEL_W)
    ) u_rs_match (
        .src_i     (id_rs_i),
        .use_i     (id_rs_use_i),
        .entries_i (entries_q),
        .stall_o   (rs_stall),
        .sel_o     (rs_fwd_sel_o)
    );

    sb_src_match #(
        .DEPTH    (DEPTH),
        .FWD_EN   (FWD_EN),
        .ALU_RDY  (ALU_RDY),
        .LOAD_RDY (LOAD_RDY),
        .SEL_W    (SEL_W)
    ) u_rt_match (
        .src_i     (id_rt_i),
        .use_i     (id_rt_use_i),
        .entries_i (entries_q),
        .stall_o   (rt_stall),
        .sel_o     (rt_fwd_sel_o)
    );

    assign id_stall_o     = id_valid_i & (rs_stall | rt_stall);
    assign inflight_cnt_o = inflight_q;
    assign stall_cnt_o    = stall_cnt_q;

    // Entry update: flush kills everything (including a same-cycle issue),
    // hold freezes, otherwise shift toward WB and load EXE with the issuing write.
    always_comb begin
        entries_d = entries_q;
        if (flush_i) begin
            for (int k = 0; k < DEPTH; k++) begin
                entries_d[k].v = 1'b0;
            end
        end else if (!pipe_hold_i) begin
            for (int k = DEPTH - 1; k > 0; k--) begin
                entries_d[k] = entries_q[k - 1];
            end
            entries_d[STG_EXE].v       = id_issue_i & id_wen_i & (id_wdest_i != '0);
            entries_d[STG_EXE].wdest   = id_wdest_i;
            entries_d[STG_EXE].is_load = id_is_load_i;
        end
    end

    // Popcount of next-state valid bits so the count tracks the entries exactly.
    always_comb begin
        inflight_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            inflight_d = inflight_d + SEL_W'(entries_d[k].v);
        end
    end

    // Saturating count of cycles where a valid ID instruction is held back.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (id_stall_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            entries_q   <= '0;
            inflight_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            entries_q   <= entries_d;
            inflight_q  <= inflight_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Issuing past a stall would let a consumer read a stale operand.
    a_no_issue_on_stall: assert property (@(posedge clk_i) disable iff (reset_i)
        !(id_issue_i && id_stall_o));

endmodule
